// File: rtl/ab_pkg.sv
// Shared ab_op field layout and select/op encodings for the address-bus generator.
package ab_pkg;

  localparam int unsigned OP_W   = 12;
  localparam int unsigned AB_W   = 16;
  localparam int unsigned BYTE_W = 8;

  // Bit positions inside ab_op = {I,P,H,F, AHB[2:0], ABL[3:0], CI}
  localparam int unsigned I_BIT   = 11;
  localparam int unsigned P_BIT   = 10;
  localparam int unsigned H_BIT   = 9;
  localparam int unsigned F_BIT   = 8;
  localparam int unsigned AHB_HI  = 7;
  localparam int unsigned AHB_LO  = 5;
  localparam int unsigned SELA_HI = 4;
  localparam int unsigned SELA_LO = 3;
  localparam int unsigned SELB_HI = 2;
  localparam int unsigned SELB_LO = 1;
  localparam int unsigned CI_BIT  = 0;

  // Low-byte adder A operand select
  localparam logic [1:0] SEL_A_ZERO = 2'b00;
  localparam logic [1:0] SEL_A_DB   = 2'b01;
  localparam logic [1:0] SEL_A_AHL  = 2'b10;
  localparam logic [1:0] SEL_A_PCL  = 2'b11;

  // Low-byte adder B operand select
  localparam logic [1:0] SEL_B_ZERO = 2'b00;
  localparam logic [1:0] SEL_B_RSVD = 2'b01;
  localparam logic [1:0] SEL_B_ABL  = 2'b10;
  localparam logic [1:0] SEL_B_REG  = 2'b11;

  // High-byte source select
  localparam logic [2:0] AHB_ZERO    = 3'b000;
  localparam logic [2:0] AHB_RSV1    = 3'b001;
  localparam logic [2:0] AHB_ONE     = 3'b010;
  localparam logic [2:0] AHB_RSV3    = 3'b011;
  localparam logic [2:0] AHB_ABH_INC = 3'b100;
  localparam logic [2:0] AHB_ABH_DEC = 3'b101;
  localparam logic [2:0] AHB_PCH     = 3'b110;
  localparam logic [2:0] AHB_DB      = 3'b111;

  // PC update op {I,P}
  localparam logic [1:0] PC_KEEP   = 2'b00;
  localparam logic [1:0] PC_FOLLOW = 2'b01;
  localparam logic [1:0] PC_RSVD   = 2'b10;
  localparam logic [1:0] PC_SAVE   = 2'b11;

  // Decoded view of one ab_op word, bit-for-bit identical to the raw layout
  typedef struct packed {
    logic       i;
    logic       p;
    logic       h;
    logic       f;
    logic [2:0] ahb;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       ci;
  } ab_op_t;

endpackage

// File: rtl/ab_gen_abl_add.sv
// Low-byte operand muxes and 8-bit adder; returns {c8, sum}.
module abl_add
  import ab_pkg::*;
(
  input  logic [1:0]        sel_a,
  input  logic [1:0]        sel_b,
  input  logic              ci,
  input  logic [BYTE_W-1:0] db,
  input  logic [BYTE_W-1:0] ahl,
  input  logic [BYTE_W-1:0] pcl,
  input  logic [BYTE_W-1:0] abl,
  input  logic [BYTE_W-1:0] reg_byte,
  output logic [BYTE_W:0]   sum_c
);

  logic [BYTE_W-1:0] opa;
  logic [BYTE_W-1:0] opb;

  // Operand A select
  always_comb begin
    opa = '0;
    case (sel_a)
      SEL_A_ZERO: opa = '0;
      SEL_A_DB:   opa = db;
      SEL_A_AHL:  opa = ahl;
      SEL_A_PCL:  opa = pcl;
      default:    opa = '0;
    endcase
  end

  // Operand B select; the reserved code reads as zero
  always_comb begin
    opb = '0;
    case (sel_b)
      SEL_B_ZERO: opb = '0;
      SEL_B_RSVD: opb = '0;
      SEL_B_ABL:  opb = abl;
      SEL_B_REG:  opb = reg_byte;
      default:    opb = '0;
    endcase
  end

  // Single 8-bit add with carry-in, carry-out in bit 8
  always_comb begin
    sum_c = {1'b0, opa} + {1'b0, opb} + (BYTE_W+1)'(ci);
  end

endmodule

// File: rtl/ab_gen.sv
// Address-bus generator: next-address computation plus AB, PC and AHL registers.
module ab_gen
  import ab_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rdy,
  input  logic [OP_W-1:0]   ab_op,
  input  logic [BYTE_W-1:0] DB,
  input  logic [BYTE_W-1:0] REG,
  output logic [AB_W-1:0]   AB,
  output logic [AB_W-1:0]   PC
);

  logic              op_i;
  logic              op_p;
  logic              op_h;
  logic              op_f;
  logic [2:0]        op_ahb;
  logic [1:0]        op_sel_a;
  logic [1:0]        op_sel_b;
  logic              op_ci;

  logic [BYTE_W-1:0] ahl;
  logic [BYTE_W:0]   abl_n;
  logic              c8;
  logic [BYTE_W-1:0] abh_n;
  logic [AB_W-1:0]   ab_n;

  logic [BYTE_W-1:0] abh_inc;
  logic [BYTE_W-1:0] abh_dec;
  logic [BYTE_W-1:0] pch_inc;
  logic [BYTE_W-1:0] db_inc;

  // Field extraction from the sequencer word
  always_comb begin
    op_i     = ab_op[I_BIT];
    op_p     = ab_op[P_BIT];
    op_h     = ab_op[H_BIT];
    op_f     = ab_op[F_BIT];
    op_ahb   = ab_op[AHB_HI:AHB_LO];
    op_sel_a = ab_op[SELA_HI:SELA_LO];
    op_sel_b = ab_op[SELB_HI:SELB_LO];
    op_ci    = ab_op[CI_BIT];
  end

  abl_add u_abl_add (
    .sel_a    (op_sel_a),
    .sel_b    (op_sel_b),
    .ci       (op_ci),
    .db       (DB),
    .ahl      (ahl),
    .pcl      (PC[BYTE_W-1:0]),
    .abl      (AB[BYTE_W-1:0]),
    .reg_byte (REG),
    .sum_c    (abl_n)
  );

  assign c8 = abl_n[BYTE_W];

  // High-byte candidates are computed in parallel with the low adder, so c8
  // only steers a final mux; AB_hi + 0xFF + c8 collapses to AB_hi or AB_hi-1.
  always_comb begin
    abh_inc = AB[AB_W-1:BYTE_W] + 8'd1;
    abh_dec = AB[AB_W-1:BYTE_W] - 8'd1;
    pch_inc = PC[AB_W-1:BYTE_W] + 8'd1;
    db_inc  = DB + 8'd1;
  end

  // High-byte select; F forces the vector page and wins over AHB
  always_comb begin
    abh_n = '0;
    if (op_f) begin
      abh_n = 8'hFF;
    end else begin
      case (op_ahb)
        AHB_ZERO:    abh_n = 8'h00;
        AHB_RSV1:    abh_n = 8'h00;
        AHB_ONE:     abh_n = 8'h01;
        AHB_RSV3:    abh_n = 8'h00;
        AHB_ABH_INC: abh_n = c8 ? abh_inc : AB[AB_W-1:BYTE_W];
        AHB_ABH_DEC: abh_n = c8 ? AB[AB_W-1:BYTE_W] : abh_dec;
        AHB_PCH:     abh_n = c8 ? pch_inc : PC[AB_W-1:BYTE_W];
        AHB_DB:      abh_n = c8 ? db_inc : DB;
        default:     abh_n = 8'h00;
      endcase
    end
  end

  assign ab_n = {abh_n, abl_n[BYTE_W-1:0]};

  // AB, PC and AHL registers; all sample pre-edge values, nothing forwarded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      AB  <= '0;
      PC  <= '0;
      ahl <= '0;
    end else if (rdy) begin
      AB <= ab_n;
      case ({op_i, op_p})
        PC_KEEP:   PC <= PC;
        PC_FOLLOW: PC <= ab_n;
        PC_RSVD:   PC <= PC;
        PC_SAVE:   PC <= AB + 16'd1;
        default:   PC <= PC;
      endcase
      if (op_h) begin
        ahl <= DB;
      end
    end
  end

endmodule

// File: tb/tb_ab_gen.sv
// Self-checking bench for ab_gen: directed address-mode sequences plus random ops
// against a behavioural model of the address arithmetic.
module tb_ab_gen;

  logic        clk;
  logic        reset_n;
  logic        rdy;
  logic [11:0] ab_op;
  logic [7:0]  DB;
  logic [7:0]  REG;
  logic [15:0] AB;
  logic [15:0] PC;

  int checks;
  int failures;

  // Model state
  int m_ab;
  int m_pc;
  int m_ahl;

  ab_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rdy     (rdy),
    .ab_op   (ab_op),
    .DB      (DB),
    .REG     (REG),
    .AB      (AB),
    .PC      (PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Next model state from the arithmetic rules of the address bus
  task automatic model_edge(input logic [11:0] op, input int db, input int rg, input logic r);
    int a, b, s, c8, lo, hi, nab, abh, pch;
    int sa, sb, ahb;
    sa  = int'(op[4:3]);
    sb  = int'(op[2:1]);
    ahb = int'(op[7:5]);
    case (sa)
      0: a = 0;
      1: a = db;
      2: a = m_ahl;
      default: a = m_pc % 256;
    endcase
    if (sb == 3) b = rg;
    else if (sb == 2) b = m_ab % 256;
    else b = 0;
    s   = a + b + int'(op[0]);
    c8  = s / 256;
    lo  = s % 256;
    abh = m_ab / 256;
    pch = m_pc / 256;
    if (op[8]) hi = 255;
    else begin
      case (ahb)
        2: hi = 1;
        4: hi = (abh + c8) % 256;
        5: hi = (abh + 255 + c8) % 256;
        6: hi = (pch + c8) % 256;
        7: hi = (db + c8) % 256;
        default: hi = 0;
      endcase
    end
    nab = hi * 256 + lo;
    if (r) begin
      if (op[11:10] == 2'b01) m_pc = nab;
      else if (op[11:10] == 2'b11) m_pc = (m_ab + 1) % 65536;
      if (op[9]) m_ahl = db;
      m_ab = nab;
    end
  endtask

  // One clock with the given inputs; DUT checked against the model after the edge
  task automatic step(input string tag, input logic [11:0] op, input logic [7:0] db,
                      input logic [7:0] rg, input logic r);
    ab_op = op;
    DB    = db;
    REG   = rg;
    rdy   = r;
    model_edge(op, int'(db), int'(rg), r);
    @(posedge clk);
    #1;
    check({tag, ".ab"}, AB, 16'(m_ab));
    check({tag, ".pc"}, PC, 16'(m_pc));
  endtask

  // Asynchronous reset between edges, held across one edge with rdy low
  task automatic async_reset(input string tag);
    #2;
    rdy     = 1'b0;
    reset_n = 1'b0;
    m_ab  = 0;
    m_pc  = 0;
    m_ahl = 0;
    #1;
    check({tag, ".ab_async"}, AB, 16'h0000);
    check({tag, ".pc_async"}, PC, 16'h0000);
    @(posedge clk);
    #1;
    check({tag, ".ab_held"}, AB, 16'h0000);
    #2;
    reset_n = 1'b1;
  endtask

  localparam logic [11:0] OP_FETCH   = 12'b0110_100_0010_1;
  localparam logic [11:0] OP_FETCH_NH = 12'b0100_100_0010_1;
  localparam logic [11:0] OP_LOAD    = 12'b0100_111_0011_0; // AB = {DB, REG}, PC follows
  localparam logic [11:0] OP_ABSX    = 12'b1110_111_1011_0;
  localparam logic [11:0] OP_BRANCH  = 12'b0110_101_0110_1;
  localparam logic [11:0] OP_STACK   = 12'b0100_010_0011_0;
  localparam logic [11:0] OP_VECTOR  = 12'b0001_000_0011_0;
  localparam logic [11:0] OP_SAVE    = 12'b1100_000_0000_0;
  localparam logic [11:0] OP_RD_AHL  = 12'b0000_000_1000_0;
  localparam logic [11:0] OP_AHL_H   = 12'b0010_000_1000_1; // reads AHL while loading it

  initial begin
    logic [15:0] pc_before;
    checks   = 0;
    failures = 0;
    rdy      = 1'b0;
    ab_op    = '0;
    DB       = '0;
    REG      = '0;
    reset_n  = 1'b1;
    m_ab = 0; m_pc = 0; m_ahl = 0;
    #1 reset_n = 1'b0;
    #1;
    check("reset.ab", AB, 16'h0000);
    check("reset.pc", PC, 16'h0000);
    #2 reset_n = 1'b1;

    // Reset mid-run from AB = 0x1234
    step("load1234", OP_LOAD, 8'h12, 8'h34, 1'b1);
    check("load1234.const", AB, 16'h1234);
    async_reset("rst1");

    // Sequential fetch
    step("setpc", OP_LOAD, 8'h02, 8'h00, 1'b1);
    check("setpc.const", PC, 16'h0200);
    step("fetch1", OP_FETCH, 8'hA9, 8'h00, 1'b1);
    check("fetch1.const", AB, 16'h0201);
    step("fetch2", OP_FETCH, 8'h44, 8'h00, 1'b1);
    check("fetch2.const", AB, 16'h0202);
    step("fetch3", OP_FETCH, 8'hF0, 8'h00, 1'b1);
    check("fetch3.const", AB, 16'h0203);
    check("fetch3.pc", PC, 16'h0203);

    // Absolute,X across a page; AHL = 0xF0 from the last fetch's DB
    step("absx", OP_ABSX, 8'h12, 8'h20, 1'b1);
    check("absx.const", AB, 16'h1310);
    check("absx.pcsave", PC, 16'h0204);

    // Page-FF wrap and AB+1 wrap
    step("setffff", OP_LOAD, 8'hFF, 8'hFF, 1'b1);
    step("fetchwrap", OP_FETCH, 8'h00, 8'h00, 1'b1);
    check("fetchwrap.const", AB, 16'h0000);
    step("setffff2", OP_LOAD, 8'hFF, 8'hFF, 1'b1);
    step("savewrap", OP_SAVE, 8'h00, 8'h00, 1'b1);
    check("savewrap.pc", PC, 16'h0000);

    // Backward branch, with and without page borrow
    step("set0305", OP_LOAD, 8'h03, 8'h05, 1'b1);
    step("branch1", OP_BRANCH, 8'hFA, 8'h00, 1'b1);
    check("branch1.const", AB, 16'h0300);
    step("set0302", OP_LOAD, 8'h03, 8'h02, 1'b1);
    step("branch2", OP_BRANCH, 8'hFA, 8'h00, 1'b1);
    check("branch2.const", AB, 16'h02FD);

    // Stack page and vector fetch
    step("stack", OP_STACK, 8'h00, 8'hFD, 1'b1);
    check("stack.const", AB, 16'h01FD);
    pc_before = PC;
    step("vector", OP_VECTOR, 8'h00, 8'hFC, 1'b1);
    check("vector.const", AB, 16'hFFFC);
    check("vector.pc", PC, pc_before);

    // Hold with rdy low while DB toggles; AHL must keep 0x5A
    step("set0400", OP_LOAD, 8'h04, 8'h00, 1'b1);
    step("holdpre", OP_FETCH, 8'h5A, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step("hold", 12'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      check("hold.const", AB, 16'h0401);
    end
    step("resume", OP_FETCH_NH, 8'h00, 8'h00, 1'b1);
    check("resume.const", AB, 16'h0402);
    step("rdahl", OP_RD_AHL, 8'h00, 8'h00, 1'b1);
    check("rdahl.const", AB, 16'h005A);

    // AHL read and write in the same cycle: old value drives the adder
    step("ahlh1", OP_AHL_H, 8'h33, 8'h00, 1'b1);
    check("ahlh1.const", AB, 16'h005B);
    step("ahlh2", OP_RD_AHL, 8'h00, 8'h00, 1'b1);
    check("ahlh2.const", AB, 16'h0033);

    // Random ops, mostly advancing, with one reset in the middle
    for (int n = 0; n < 400; n++) begin
      step("rand", 12'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      if (n == 200) async_reset("rst2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
